// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: word width, reset/halt defaults and the
// IF/ID pipeline register contents.
package arm_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [WORD_W-1:0] HALT_INSTR_DEF = 32'hEAFF_FFFF;
    localparam logic [WORD_W-1:0] BUBBLE_INSTR   = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_STEP        = 32'd4;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
        logic              valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{pc: '0, instr: BUBBLE_INSTR, valid: 1'b0};

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: holds PC+4, instruction and valid; flush inserts a
// bubble and takes priority over the hold enable.
module ifid_reg
    import arm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic [WORD_W-1:0] pc_in,
    input  logic [WORD_W-1:0] instr_in,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] instr,
    output logic              valid
);

    ifid_t stage;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage <= IFID_BUBBLE;
        end else if (flush) begin
            stage <= IFID_BUBBLE;
        end else if (en) begin
            stage <= '{pc: pc_in, instr: instr_in, valid: 1'b1};
        end
    end

    assign pc    = stage.pc;
    assign instr = stage.instr;
    assign valid = stage.valid;

endmodule

// File: rtl/if_stage_fetch.sv
// Fetch stage: program counter, next-PC selection, IF/ID register, fetch
// statistics and sticky halt detection.
module if_stage_fetch
    import arm_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_addr,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    output logic [WORD_W-1:0] ifid_pc,
    output logic [WORD_W-1:0] ifid_instr,
    output logic              ifid_valid,
    output logic [WORD_W-1:0] fetch_count,
    output logic              halted
);

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic              advance;

    // Branch redirect outranks freeze; only a plain advance counts as a fetch.
    assign pc_plus4  = pc + PC_STEP;
    assign advance   = !branch_taken && !freeze;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= branch_addr;
        end else if (!freeze) begin
            pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            halted      <= 1'b0;
        end else if (advance) begin
            fetch_count <= fetch_count + 1'b1;
            if (imem_data == HALT_INSTR) begin
                halted <= 1'b1;
            end
        end
    end

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .rst      (rst),
        .en       (!freeze),
        .flush    (branch_taken),
        .pc_in    (pc_plus4),
        .instr_in (imem_data),
        .pc       (ifid_pc),
        .instr    (ifid_instr),
        .valid    (ifid_valid)
    );

endmodule

// File: tb/tb_if_stage_fetch.sv
// Self-checking bench for if_stage_fetch: directed vector table, async reset
// sequence and randomized traffic against a behavioural fetch model.
module tb_if_stage_fetch;

    localparam logic [31:0] HALT = 32'hEAFF_FFFF;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [31:0] fetch_count;
    logic        halted;

    logic [31:0] mem [64];

    int vectors;
    int miscompares;

    // behavioural model state
    logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
    logic        m_valid, m_halted;

    if_stage_fetch #(.RESET_PC(32'h0), .HALT_INSTR(HALT)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .ifid_pc      (ifid_pc),
        .ifid_instr   (ifid_instr),
        .ifid_valid   (ifid_valid),
        .fetch_count  (fetch_count),
        .halted       (halted)
    );

    // combinational instruction memory, aliased modulo 256 bytes
    assign imem_data = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        f;
        logic        b;
        logic [31:0] addr;
        logic [31:0] e_addr;
        logic [31:0] e_ipc;
        int          e_idx;   // -1 means bubble (0)
        logic        e_valid;
        logic [31:0] e_cnt;
        logic        e_halt;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".imem_addr"},   imem_addr,   m_pc);
        chk({tag, ".ifid_pc"},     ifid_pc,     m_ipc);
        chk({tag, ".ifid_instr"},  ifid_instr,  m_instr);
        chk({tag, ".ifid_valid"},  {31'b0, ifid_valid}, {31'b0, m_valid});
        chk({tag, ".fetch_count"}, fetch_count, m_cnt);
        chk({tag, ".halted"},      {31'b0, halted},     {31'b0, m_halted});
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ipc = '0; m_instr = '0; m_cnt = '0;
        m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // one clock edge of the fetch stage, described from the priority rules
    task automatic model_edge(input logic f, input logic b, input logic [31:0] a);
        logic [31:0] w;
        if (b) begin
            m_pc = a; m_ipc = 0; m_instr = 0; m_valid = 0;
        end else if (!f) begin
            w = mem[m_pc[7:2]];
            m_instr = w;
            m_ipc = m_pc + 4;
            m_valid = 1;
            m_cnt = m_cnt + 1;
            if (w == HALT) m_halted = 1;
            m_pc = m_pc + 4;
        end
    endtask

    task automatic step(input logic f, input logic b, input logic [31:0] a);
        freeze = f; branch_taken = b; branch_addr = a;
        model_edge(f, b, a);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic f, logic b, logic [31:0] addr, logic [31:0] ea,
                                logic [31:0] ei, int idx, logic ev, logic [31:0] ec, logic eh);
        vec_t v;
        v.f = f; v.b = b; v.addr = addr; v.e_addr = ea; v.e_ipc = ei;
        v.e_idx = idx; v.e_valid = ev; v.e_cnt = ec; v.e_halt = eh;
        return v;
    endfunction

    initial begin
        logic [31:0] exp_instr;
        logic        rf, rb;
        logic [31:0] ra;
        vectors = 0;
        miscompares = 0;

        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT) mem[i] = mem[i] ^ 32'h1;
        end
        mem[46] = HALT;

        // directed table: free run, freeze, branch, branch+freeze, halt, wrap
        tbl[0]  = mk(0, 0, 0,            32'h04, 32'h04,  0, 1, 1, 0);
        tbl[1]  = mk(0, 0, 0,            32'h08, 32'h08,  1, 1, 2, 0);
        tbl[2]  = mk(0, 0, 0,            32'h0C, 32'h0C,  2, 1, 3, 0);
        tbl[3]  = mk(1, 0, 0,            32'h0C, 32'h0C,  2, 1, 3, 0);
        tbl[4]  = mk(1, 0, 0,            32'h0C, 32'h0C,  2, 1, 3, 0);
        tbl[5]  = mk(1, 0, 0,            32'h0C, 32'h0C,  2, 1, 3, 0);
        tbl[6]  = mk(0, 0, 0,            32'h10, 32'h10,  3, 1, 4, 0);
        tbl[7]  = mk(0, 0, 0,            32'h14, 32'h14,  4, 1, 5, 0);
        tbl[8]  = mk(0, 1, 32'h70,       32'h70, 32'h00, -1, 0, 5, 0);
        tbl[9]  = mk(0, 0, 0,            32'h74, 32'h74, 28, 1, 6, 0);
        tbl[10] = mk(1, 1, 32'h94,       32'h94, 32'h00, -1, 0, 6, 0);
        tbl[11] = mk(0, 0, 0,            32'h98, 32'h98, 37, 1, 7, 0);
        tbl[12] = mk(0, 1, 32'hB8,       32'hB8, 32'h00, -1, 0, 7, 0);
        tbl[13] = mk(0, 0, 0,            32'hBC, 32'hBC, 46, 1, 8, 1);
        tbl[14] = mk(0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h00, -1, 0, 8, 1);
        tbl[15] = mk(0, 0, 0,            32'h00, 32'h00, 63, 1, 9, 1);
        tbl[16] = mk(0, 0, 0,            32'h04, 32'h04,  0, 1, 10, 1);

        // reset state, held asynchronously
        rst = 1'b0; freeze = 0; branch_taken = 0; branch_addr = 0;
        model_reset();
        #1;
        chk("rst.imem_addr",   imem_addr,   32'h0);
        chk("rst.ifid_pc",     ifid_pc,     32'h0);
        chk("rst.ifid_instr",  ifid_instr,  32'h0);
        chk("rst.ifid_valid",  {31'b0, ifid_valid}, 32'h0);
        chk("rst.fetch_count", fetch_count, 32'h0);
        chk("rst.halted",      {31'b0, halted},     32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold.imem_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            freeze = tbl[i].f; branch_taken = tbl[i].b; branch_addr = tbl[i].addr;
            @(posedge clk);
            #1;
            exp_instr = (tbl[i].e_idx < 0) ? 32'h0 : mem[tbl[i].e_idx];
            chk($sformatf("tbl%0d.imem_addr", i),   imem_addr,   tbl[i].e_addr);
            chk($sformatf("tbl%0d.ifid_pc", i),     ifid_pc,     tbl[i].e_ipc);
            chk($sformatf("tbl%0d.ifid_instr", i),  ifid_instr,  exp_instr);
            chk($sformatf("tbl%0d.ifid_valid", i),  {31'b0, ifid_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("tbl%0d.fetch_count", i), fetch_count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d.halted", i),      {31'b0, halted},     {31'b0, tbl[i].e_halt});
        end

        // async reset mid-cycle: outputs clear without any clock edge
        freeze = 0; branch_taken = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.imem_addr",   imem_addr,   32'h0);
        chk("arst.ifid_pc",     ifid_pc,     32'h0);
        chk("arst.ifid_instr",  ifid_instr,  32'h0);
        chk("arst.ifid_valid",  {31'b0, ifid_valid}, 32'h0);
        chk("arst.fetch_count", fetch_count, 32'h0);
        chk("arst.halted",      {31'b0, halted},     32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // first edge after release latches mem[RESET_PC>>2]
        step(0, 0, 0);
        chk("rel.ifid_instr", ifid_instr, mem[0]);
        chk_model("rel");

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rf = ($urandom_range(0, 3) == 0);
            rb = ($urandom_range(0, 9) == 0);
            ra = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 + {$urandom_range(0, 1), 2'b00}
                                              : {24'h0, $urandom_range(0, 63), 2'b00};
            step(rf, rb, ra);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
